// File: rtl/ff128_unpack_pkg.sv
// Shared definitions for the ff128_unpack wide-to-narrow word unpacker.
// Holds the FSM state type, the narrow word width and the legal range
// for the number of words per input beat.
package ff128_unpack_pkg;

    // Width of one narrow output word.
    localparam int unsigned WORD_W = 32;

    // Legal bounds for the IN_WORDS parameter.
    localparam int unsigned IN_WORDS_MIN = 2;
    localparam int unsigned IN_WORDS_MAX = 8;

    // Width of the word index; covers up to IN_WORDS_MAX words.
    localparam int unsigned IDX_W = 3;

    // Unpacker FSM: EMPTY waits for a beat, DRAIN emits its words.
    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } state_e;

endpackage

// File: rtl/ff128_word_mux.sv
// Selects one 32-bit word out of the held wide beat.
// Word order is set by the FF128_UNPACK_MSW_FIRST_EN macro: when defined,
// word 0 is the most significant word; otherwise word 0 is in_data[31:0].
module ff128_word_mux
    import ff128_unpack_pkg::*;
#(
    parameter int unsigned IN_WORDS = 4
) (
    input  logic [WORD_W*IN_WORDS-1:0] hold,
    input  logic [IDX_W-1:0]           idx,
    output logic [WORD_W-1:0]          word
);

    // Decode idx into a word select; unused idx values give zero.
    always_comb begin
        word = '0;
        for (int i = 0; i < int'(IN_WORDS); i++) begin
            if (idx == IDX_W'(i)) begin
`ifdef FF128_UNPACK_MSW_FIRST_EN
                word = hold[WORD_W*(int'(IN_WORDS)-1-i) +: WORD_W];
`else
                word = hold[WORD_W*i +: WORD_W];
`endif
            end
        end
    end

endmodule

// File: rtl/ff128_unpack.sv
// Wide-to-narrow unpacker: takes IN_WORDS x 32-bit beats and emits them one
// 32-bit word per cycle. A two-state FSM (EMPTY/DRAIN) with a word counter
// handles the handshakes; in_ready passes through combinationally on the last
// word so consecutive beats stream without a bubble.
// Optional build macro: FF128_UNPACK_MSW_FIRST_EN (emit most significant word
// first; see ff128_word_mux).
module ff128_unpack
    import ff128_unpack_pkg::*;
#(
    parameter int unsigned IN_WORDS = 4
) (
    input  logic                       clock,
    input  logic                       sclr,
    input  logic [WORD_W*IN_WORDS-1:0] in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       flush,
    output logic [WORD_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic [IDX_W-1:0]           out_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_WORDS - 1);

    // Reject illegal configurations at elaboration.
    generate
        if (IN_WORDS < IN_WORDS_MIN || IN_WORDS > IN_WORDS_MAX) begin : g_bad_cfg
            $error("ff128_unpack: IN_WORDS out of range");
        end
    endgenerate

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [WORD_W*IN_WORDS-1:0] hold_q, hold_d;

    logic [WORD_W-1:0] sel_word;
    logic              in_xfer;
    logic              out_xfer;

    ff128_word_mux #(
        .IN_WORDS(IN_WORDS)
    ) u_word_mux (
        .hold(hold_q),
        .idx (idx_q),
        .word(sel_word)
    );

    // Output and handshake decode from the current state.
    always_comb begin
        out_valid = (state_q == DRAIN);
        out_last  = out_valid && (idx_q == LAST_IDX);
        out_idx   = idx_q;
        out_data  = out_valid ? sel_word : '0;
        // Flush blocks input so nothing is captured in the flush cycle.
        in_ready  = !flush && ((state_q == EMPTY) || (out_last && out_ready));
        in_xfer   = in_valid && in_ready;
        out_xfer  = out_valid && out_ready;
    end

    // Next-state, counter and hold register update.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        if (flush) begin
            state_d = EMPTY;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        hold_d  = in_data;
                        idx_d   = '0;
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_xfer) begin
                        if (!out_last) begin
                            idx_d = idx_q + IDX_W'(1);
                        end else if (in_xfer) begin
                            // Last word leaves as the next beat arrives.
                            hold_d = in_data;
                            idx_d  = '0;
                        end else begin
                            idx_d   = '0;
                            state_d = EMPTY;
                        end
                    end
                end
                default: begin
                    state_d = EMPTY;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // State registers; sclr wins over flush and any transfer.
    always_ff @(posedge clock) begin
        if (sclr) begin
            state_q <= EMPTY;
            idx_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_ff128_unpack.sv
// Directed testbench for ff128_unpack with IN_WORDS=4.
// Expected word order follows FF128_UNPACK_MSW_FIRST_EN when defined.
module tb_ff128_unpack;

    localparam int unsigned NW = 4;

    logic          clock;
    logic          sclr;
    logic [127:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [2:0]    out_idx;

    int unsigned n_checks;
    int unsigned n_pass;

    localparam logic [127:0] BEAT_A = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] BEAT_B = 128'h88888888_77777777_66666666_55555555;

    ff128_unpack #(
        .IN_WORDS(NW)
    ) dut (
        .clock    (clock),
        .sclr     (sclr),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .flush    (flush),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .out_idx  (out_idx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Word i of a beat in the configured emission order.
    function automatic logic [31:0] exp_word(input logic [127:0] beat, input int i);
`ifdef FF128_UNPACK_MSW_FIRST_EN
        return beat[32*(3-i) +: 32];
`else
        return beat[32*i +: 32];
`endif
    endfunction

    // Advance one clock; settle just after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_data"}, out_data, 32'd0);
        check({tag, "_last"}, {31'd0, out_last}, 32'd0);
        check({tag, "_idx"}, {29'd0, out_idx}, 32'd0);
    endtask

    // Present a beat for one accepted cycle from EMPTY.
    task automatic load(input logic [127:0] beat);
        in_data  = beat;
        in_valid = 1'b1;
        #1;
        check("load_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        sclr      = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        sclr = 1'b0;
        #1;

        // Reset state
        check_idle("rst");
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single beat, consumer always ready
        out_ready = 1'b1;
        load(BEAT_A);
        for (int i = 0; i < 4; i++) begin
            check("single_valid", {31'd0, out_valid}, 32'd1);
            check("single_data", out_data, exp_word(BEAT_A, i));
            check("single_idx", {29'd0, out_idx}, 32'(i));
            check("single_last", {31'd0, out_last}, {31'd0, i == 3});
            check("single_in_ready", {31'd0, in_ready}, {31'd0, i == 3});
            tick();
        end
        check_idle("single_end");

        // Back-to-back beats, no bubble
        in_data  = BEAT_A;
        in_valid = 1'b1;
        tick();
        in_data = BEAT_B;
        #1;
        for (int k = 0; k < 8; k++) begin
            check("b2b_valid", {31'd0, out_valid}, 32'd1);
            check("b2b_data", out_data, exp_word(k < 4 ? BEAT_A : BEAT_B, k % 4));
            check("b2b_idx", {29'd0, out_idx}, 32'(k % 4));
            check("b2b_in_ready", {31'd0, in_ready}, {31'd0, (k == 3) || (k == 7)});
            tick();
            if (k == 3) begin
                in_valid = 1'b0;
                #1;
            end
        end
        check_idle("b2b_end");

        // Backpressure at idx 1
        load(BEAT_A);
        tick();
        out_ready = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_data", out_data, exp_word(BEAT_A, 1));
            check("bp_idx", {29'd0, out_idx}, 32'd1);
            check("bp_last", {31'd0, out_last}, 32'd0);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        for (int i = 1; i < 4; i++) begin
            check("bp_drain_data", out_data, exp_word(BEAT_A, i));
            tick();
        end
        check_idle("bp_end");

        // Flush at idx 2 with a competing input
        load(BEAT_A);
        tick();
        tick();
        check("fl_pre_idx", {29'd0, out_idx}, 32'd2);
        flush    = 1'b1;
        in_data  = BEAT_B;
        in_valid = 1'b1;
        #1;
        check("fl_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_idle("fl_post");
        check("fl_post_in_ready", {31'd0, in_ready}, 32'd1);
        load(BEAT_B);
        check("fl_restart_idx", {29'd0, out_idx}, 32'd0);
        check("fl_restart_data", out_data, exp_word(BEAT_B, 0));
        for (int i = 0; i < 4; i++) tick();
        check_idle("fl_end");

        // Synchronous reset mid-drain
        load(BEAT_A);
        tick();
        check("rd_pre_idx", {29'd0, out_idx}, 32'd1);
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        #1;
        check_idle("rd_post");
        check("rd_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check_idle("rd_no_residual");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
